// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// The queue entry pairs a fetched word with the PC+4 that decode needs.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0020;
  localparam logic [31:0] PC_STEP           = 32'd4;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps mod 2^32 by construction.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO with flush; head is visible combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output T                           head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T               mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           full;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC generation, single-outstanding imem handshake, prefetch queue
// and the IF/ID output register with stall, redirect and bubble insertion.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       clr,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  input  logic                       id_stall,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       id_valid,
  output logic [31:0]                id_instr,
  output logic [31:0]                id_pc4,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]  fetch_pc;
  logic [31:0]  tag_pc4;
  logic         outstanding;
  logic         discard;
  logic         issue;
  logic         rsp;
  logic         push;
  logic         pop;
  logic         q_empty;
  fetch_entry_t rsp_entry;
  fetch_entry_t head;

  // Request side: at most one in flight, and only when the queue has room for it.
  assign imem_req  = !clr && !redirect && !outstanding && (q_count < CW'(DEPTH));
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_gnt;

  // A zero-wait memory answers in the grant cycle, before outstanding is set.
  assign rsp             = imem_rvalid && (outstanding || issue);
  assign rsp_entry.pc4   = outstanding ? tag_pc4 : pc_next(fetch_pc);
  assign rsp_entry.instr = imem_rdata;
  assign push            = rsp && !discard && !redirect;
  assign pop             = !redirect && !id_stall && !q_empty;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .clr       (clr),
    .push      (push),
    .push_data (rsp_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Fetch control: PC, in-flight flag and the drop-next-response flag.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fetch_pc    <= RESET_PC;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      if (redirect)   fetch_pc <= redirect_pc;
      else if (issue) fetch_pc <= pc_next(fetch_pc);

      if (rsp)        outstanding <= 1'b0;
      else if (issue) outstanding <= 1'b1;

      // The word still in flight at redirect belongs to the old path.
      if (redirect) discard <= outstanding && !imem_rvalid;
      else if (rsp) discard <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tag_pc4 <= pc_next(fetch_pc);
  end

  // IF/ID register boundary.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc4   <= '0;
    end else if (redirect) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end else if (!id_stall) begin
      if (!q_empty) begin
        id_valid <= 1'b1;
        id_instr <= head.instr;
        id_pc4   <= head.pc4;
      end else begin
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-configurable instruction memory plus a
// queue-based reference model of the fetch stage, compared every cycle.
`timescale 1ns/1ps
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam int          CW    = $clog2(DEPTH+1);
  localparam logic [31:0] NOP   = 32'h0000_0020;

  logic          clk = 1'b0;
  logic          clr;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic          id_stall;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          id_valid;
  logic [31:0]   id_instr;
  logic [31:0]   id_pc4;
  logic [CW-1:0] q_count;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .clr(clr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Memory side: pending responses in issue order, each with its due cycle.
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];
  int    lat_mode;   // fixed latency, or -1 for random 0..3 per request
  bit    gnt_en;
  int    gnt_pct;

  // Reference model: program-order queue of {pc4, word} plus fetch state.
  fetch_entry_t mq[$];
  logic [31:0]  m_pc, m_tag, m_instr, m_pc4;
  bit           m_out, m_disc, m_valid;
  bit           e_req;
  logic [97+CW:0] obs, exp_v;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic void model_reset();
    m_pc = 32'h0; m_tag = 32'h0; m_instr = NOP; m_pc4 = 32'h0;
    m_out = 0; m_disc = 0; m_valid = 0;
    mq.delete();
  endfunction

  // One clock cycle: drive inputs at the falling edge, answer the memory
  // handshake, snapshot DUT and model, then advance the model past the edge.
  task automatic tick(input bit stall, input bit redir, input logic [31:0] rpc);
    int lat; bit issue, accept; logic [31:0] rsp_pc4; fetch_entry_t e;
    @(negedge clk);
    cyc++;
    id_stall = stall; redirect = redir; redirect_pc = rpc;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 32'h0;
    #1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1; imem_rdata = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
    imem_gnt = gnt_en && ($urandom_range(99) < gnt_pct);
    #1;
    if (imem_req && imem_gnt) begin
      lat = (lat_mode < 0) ? int'($urandom_range(3)) : lat_mode;
      if (lat == 0 && !imem_rvalid) begin
        imem_rvalid = 1; imem_rdata = mem_word(imem_addr);
      end else begin
        pend.push_back('{addr: imem_addr, due: cyc + ((lat == 0) ? 1 : lat)});
      end
    end
    #1;
    e_req = !clr && !redir && !m_out && (mq.size() < DEPTH);
    obs   = {imem_req, imem_req ? imem_addr : 32'h0, id_valid, id_instr, id_pc4, q_count};
    exp_v = {e_req, e_req ? m_pc : 32'h0, m_valid, m_instr, m_pc4, CW'(mq.size())};
    if (!clr) begin
      issue   = e_req && imem_gnt;
      accept  = imem_rvalid && (m_out || issue);
      rsp_pc4 = m_out ? m_tag : m_pc + 32'd4;
      if (redir) begin
        mq.delete(); m_valid = 0; m_instr = NOP; m_pc = rpc;
        m_disc = m_out && !imem_rvalid;
        m_out  = m_out && !imem_rvalid;
      end else begin
        if (!stall) begin
          if (mq.size() > 0) begin
            e = mq.pop_front(); m_valid = 1; m_instr = e.instr; m_pc4 = e.pc4;
          end else begin
            m_valid = 0; m_instr = NOP;
          end
        end
        if (accept) begin
          if (!m_disc) mq.push_back('{pc4: rsp_pc4, instr: imem_rdata});
          m_out = 0; m_disc = 0;
        end else if (issue) begin
          m_out = 1;
        end
        if (issue) begin m_tag = m_pc + 32'd4; m_pc = m_pc + 32'd4; end
      end
    end
  endtask

  task automatic apply_reset(input bit keep_pend);
    clr = 1; id_stall = 0; redirect = 0; imem_gnt = 0; imem_rvalid = 0;
    model_reset();
    if (!keep_pend) pend.delete();
    repeat (2) @(posedge clk);
    #2 clr = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
    checks++; if (id_instr !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", id_instr, NOP); end
    checks++; if (id_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got=%h exp=0", id_pc4); end
    checks++; if (q_count !== '0) begin errors++; $display("FAIL reset_qcount got=%0d exp=0", q_count); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    apply_reset(0);
  endtask

  task automatic test_zero_wait();
    lat_mode = 0; gnt_pct = 100; gnt_en = 1;
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, 32'h0);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL zero_wait_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (i < 8) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'(4*i)) begin
          errors++; $display("FAIL zero_wait_addr i=%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, 32'(4*i));
        end
      end
      checks++;
      if (i < 2) begin
        if (id_valid !== 1'b0) begin errors++; $display("FAIL zero_wait_early i=%0d got=%b exp=0", i, id_valid); end
      end else if (id_valid !== 1'b1 || id_pc4 !== 32'(4*(i-1)) || id_instr !== mem_word(32'(4*(i-2)))) begin
        errors++; $display("FAIL zero_wait_stream i=%0d got=%b/%h/%h exp=1/%h/%h",
                           i, id_valid, id_pc4, id_instr, 32'(4*(i-1)), mem_word(32'(4*(i-2))));
      end
    end
  endtask

  task automatic test_latency3();
    bit waiting = 0; int nbub = 0; int nval = 0;
    lat_mode = 3;
    for (int i = 0; i < 24; i++) begin
      tick(0, 0, 32'h0);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL lat3_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (waiting) begin
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL lat3_no_issue cyc=%0d got=%b exp=0", cyc, imem_req); end
      end
      if (!id_valid) begin
        nbub++;
        checks++; if (id_instr !== NOP) begin errors++; $display("FAIL lat3_bubble cyc=%0d got=%h exp=%h", cyc, id_instr, NOP); end
      end else nval++;
      if (imem_rvalid) waiting = 0;
      if (imem_req && imem_gnt && !imem_rvalid) waiting = 1;
    end
    checks++; if (nbub < 6 || nval < 4) begin errors++; $display("FAIL lat3_mix got=%0d/%0d exp>=6/>=4", nbub, nval); end
  endtask

  task automatic test_stall();
    logic [64:0] frozen;
    lat_mode = 0;
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 32'h0);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL stall_pre_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    end
    frozen = '0;
    for (int k = 0; k < 6; k++) begin
      tick(1, 0, 32'h0);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL stall_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (k == 0) frozen = {id_valid, id_instr, id_pc4};
      else begin
        checks++; if ({id_valid, id_instr, id_pc4} !== frozen) begin
          errors++; $display("FAIL stall_frozen k=%0d got=%h exp=%h", k, {id_valid, id_instr, id_pc4}, frozen);
        end
      end
    end
    checks++; if (q_count !== CW'(DEPTH) || imem_req !== 1'b0) begin
      errors++; $display("FAIL stall_full got=%0d/%b exp=%0d/0", q_count, imem_req, DEPTH);
    end
    for (int r = 0; r < 6; r++) begin
      tick(0, 0, 32'h0);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL stall_post_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (r >= 1 && r <= 4) begin
        checks++;
        if (id_valid !== 1'b1 || id_pc4 !== frozen[31:0] + 32'(4*r) || id_instr !== mem_word(frozen[31:0] + 32'(4*(r-1)))) begin
          errors++; $display("FAIL stall_drain r=%0d got=%b/%h exp=1/%h", r, id_valid, id_pc4, frozen[31:0] + 32'(4*r));
        end
      end
    end
  endtask

  task automatic test_redirect_outstanding();
    bit found = 0; bit seen_issue = 0; bit seen_valid = 0;
    apply_reset(0);
    lat_mode = 3; gnt_pct = 100; gnt_en = 1;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(0, 0, 32'h0);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL redir_pre_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (imem_req && imem_gnt && imem_addr == 32'h10) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL redir_wait_0x10 got=timeout exp=issue"); end
    tick(0, 1, 32'h100);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL redir_cycle_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req_forced got=%b exp=0", imem_req); end
    for (int i = 0; i < 40 && !seen_valid; i++) begin
      tick(0, 0, 32'h0);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL redir_post_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (imem_req && !seen_issue) begin
        seen_issue = 1;
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL redir_first_addr got=%h exp=00000100", imem_addr); end
      end
      if (id_valid) begin
        seen_valid = 1;
        checks++; if (id_pc4 !== 32'h104) begin errors++; $display("FAIL redir_first_pc4 got=%h exp=00000104", id_pc4); end
      end
    end
    checks++; if (!seen_valid) begin errors++; $display("FAIL redir_resume got=timeout exp=valid"); end
  endtask

  task automatic test_redirect_stall_full();
    bit full = 0; bit seen = 0;
    lat_mode = 0;
    for (int i = 0; i < 30 && !full; i++) begin
      tick(1, 0, 32'h0);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL rsf_fill_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (q_count == CW'(DEPTH)) full = 1;
    end
    checks++; if (!full) begin errors++; $display("FAIL rsf_fill got=timeout exp=full"); end
    tick(1, 1, 32'h200);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL rsf_redir_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    tick(1, 0, 32'h0);
    checks++;
    if (id_valid !== 1'b0 || id_instr !== NOP || q_count !== '0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++; $display("FAIL rsf_flushed got=%b/%h/%0d/%b/%h exp=0/%h/0/1/00000200",
                         id_valid, id_instr, q_count, imem_req, imem_addr, NOP);
    end
    for (int i = 0; i < 8 && !seen; i++) begin
      tick(0, 0, 32'h0);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL rsf_post_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (id_valid) begin
        seen = 1;
        checks++; if (id_pc4 !== 32'h204) begin errors++; $display("FAIL rsf_first_pc4 got=%h exp=00000204", id_pc4); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rsf_resume got=timeout exp=valid"); end
  endtask

  task automatic test_clr_midburst();
    bit found = 0; bit drained = 0;
    lat_mode = 6;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(0, 0, 32'h0);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL clr_pre_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (imem_req && imem_gnt) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL clr_wait_issue got=timeout exp=issue"); end
    tick(0, 0, 32'h0);
    #1 clr = 1;
    #1;
    checks++;
    if (id_valid !== 1'b0 || id_instr !== NOP || id_pc4 !== 32'h0 || q_count !== '0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL clr_async got=%b/%h/%h/%0d/%b exp=0/%h/0/0/0", id_valid, id_instr, id_pc4, q_count, imem_req, NOP);
    end
    model_reset();
    gnt_en = 0;
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 32'h0);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL clr_hold_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    end
    @(posedge clk);
    #2 clr = 0;
    for (int i = 0; i < 10 && !drained; i++) begin
      tick(0, 0, 32'h0);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL clr_stray_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
      if (pend.size() == 0) drained = 1;
    end
    checks++; if (!drained) begin errors++; $display("FAIL clr_stray got=timeout exp=delivered"); end
    gnt_en = 1; lat_mode = 0;
    tick(0, 0, 32'h0);
    checks++;
    if (q_count !== '0 || id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL clr_restart got=%0d/%b/%b/%h exp=0/0/1/00000000", q_count, id_valid, imem_req, imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 32'h0);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL clr_post_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    end
  endtask

  task automatic test_random();
    bit st, rd; logic [31:0] rpc;
    apply_reset(0);
    lat_mode = -1; gnt_pct = 70; gnt_en = 1;
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(99) < 25);
      rd  = ($urandom_range(99) < 4);
      rpc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      tick(st, rd, rpc);
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, obs, exp_v); end
    end
  endtask

  initial begin
    clr = 1; id_stall = 0; redirect = 0; redirect_pc = 32'h0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 32'h0;
    gnt_en = 1; gnt_pct = 100; lat_mode = 0;
    model_reset();
    test_reset();
    test_zero_wait();
    test_latency3();
    test_stall();
    test_redirect_outstanding();
    test_redirect_stall_full();
    test_clr_midburst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
